sdram_access_arbiter: RTL and testbench
=======================================

SDRAM_ACCESS_ARBITER -- requirements
Module: sdram_access_arbiter

Interface
REQ-001 The block SHALL have parameter REFI, default 780: clk cycles between refresh requests.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4: consecutive display grants allowed while a user request waits.
REQ-003 Port clk, input, 1: system clock.
REQ-004 Port rst, input, 1: reset, asynchronous, active-low.
REQ-005 Port disp_req / disp_addr, input, 1/22: display read request, address {page[2:0], row[8:0], col[9:0]}.
REQ-006 Port disp_gnt / disp_valid / disp_data, output, 1/1/16: display grant pulse, read-data strobe, read data.
REQ-007 Port wr_req / wr_addr / wr_data, input, 1/22/16: user write request, address, data.
REQ-008 Port wr_gnt, output, 1: user write grant pulse.
REQ-009 Port rd_req / rd_addr, input, 1/22: user read request and address.
REQ-010 Port rd_gnt / rd_valid / rd_data, output, 1/1/16: user read grant pulse, data strobe, data.
REQ-011 Port mem_cmd_vld / mem_cmd / mem_addr / mem_wdata, output, 1/2/22/16: controller command; cmd encoding 01 read, 10 write, 11 refresh.
REQ-012 Port mem_busy / mem_rvalid / mem_rdata, input, 1/1/16: controller busy, read strobe, read data.
REQ-013 Port ref_overrun, output, 1: sticky flag, refresh interval missed.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, GUARD, WAIT.
REQ-015 IDLE: when mem_busy=0 and any source is pending, the FSM SHALL latch the winner's cmd, addr, wdata and owner, then go to ISSUE.
REQ-016 ISSUE: mem_cmd_vld and the winner's gnt SHALL be 1 for exactly this one cycle; next state is GUARD.
REQ-017 GUARD: mem_busy SHALL be ignored for one cycle; next state is WAIT.
REQ-018 WAIT: the FSM SHALL return to IDLE on the first cycle with mem_busy=0.
REQ-019 Issue latency SHALL be 1 cycle: mem_cmd_vld is asserted the cycle after IDLE samples a request with mem_busy=0.
REQ-020 Fixed priority SHALL be: refresh pending > display > user.
REQ-021 Between wr and rd, the block SHALL use round-robin; after reset, write is favoured.
REQ-022 A starvation counter SHALL count consecutive display grants while wr_req or rd_req=1.
REQ-023 When that counter equals STARVE_MAX, user SHALL outrank display, but not refresh.
REQ-024 The starvation counter SHALL clear on any user grant, and when no user request is pending.
REQ-025 Requesters SHALL hold req, addr and data stable until their gnt.
REQ-026 The arbiter SHALL never issue a second command before returning to IDLE.
REQ-027 Read return SHALL be zero latency:
- disp_data and rd_data = mem_rdata;
- disp_valid = mem_rvalid & owner==DISP;
- rd_valid = mem_rvalid & owner==USER_RD.
REQ-028 mem_rvalid outside a read ownership SHALL be dropped.
REQ-029 The refresh timer SHALL count 0..REFI-1, wrap, and set ref_pending on wrap.
REQ-030 ref_pending SHALL clear in the ISSUE cycle of a refresh command.
REQ-031 A wrap while ref_pending=1 SHALL set ref_overrun, which stays set until reset.
REQ-032 If a wrap and a refresh ISSUE coincide, ref_pending SHALL stay 1 and ref_overrun SHALL NOT be set.
REQ-033 A request withdrawn before grant SHALL be ignored, with no error.

Reset
REQ-034 Reset SHALL force:
- state IDLE;
- all gnt, valid, mem_cmd_vld and ref_overrun = 0;
- mem_cmd = 00, mem_addr = 0, mem_wdata = 0;
- timer = 0, ref_pending = 0, starvation counter = 0;
- round-robin pointer favouring write.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction, with no grant or valid on release.

Structure
REQ-036 Shared package sdram_arb_pkg SHALL hold the cmd encoding, state enum, owner enum (NONE, DISP, USER_WR, USER_RD, REF) and address field widths.
REQ-037 The refresh timer SHALL be sub-module sdram_refresh_timer, with ports clk, rst, ref_ack, ref_pending, ref_overrun.

Verification
REQ-038 The bench SHALL cover:
- Single write: wr_req=1, wr_addr=0x012345, wr_data=0xBEEF, mem_busy idle -> 1 cycle later, mem_cmd_vld=1, mem_cmd=10, mem_addr=0x012345, mem_wdata=0xBEEF, wr_gnt=1, all for 1 cycle.
- Starvation: disp_req and wr_req held continuously -> 4 disp_gnt, then wr_gnt, then disp_gnt resumes.
- Refresh: REFI=780 with disp_req held -> refresh command (mem_cmd=11) issued within one transaction after cycle 780; no overrun.
- Overrun: mem_busy held 1 for 1600 cycles -> ref_overrun=1 at cycle 1560 and stays set.
- Read return: rd_req granted, mem_rvalid pulsed with mem_rdata=0x1234 -> rd_valid=1, rd_data=0x1234, disp_valid=0.
- Reset mid-WAIT: rst=0 during WAIT -> all outputs at reset values; no grant after release.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM access arbiter: command codes,
// FSM states, transaction owners and address field widths.
package sdram_arb_pkg;

    localparam int PAGE_W = 3;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;
    localparam int ADDR_W = PAGE_W + ROW_W + COL_W;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_RD  = 2'b01,
        CMD_WR  = 2'b10,
        CMD_REF = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT
    } state_t;

    typedef enum logic [2:0] {
        OWN_NONE,
        OWN_DISP,
        OWN_USER_WR,
        OWN_USER_RD,
        OWN_REF
    } owner_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer with pending request
// and sticky overrun flag for missed refresh intervals.
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int REFI = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_ack,
    output logic ref_pending,
    output logic ref_overrun
);

    localparam int TW = (REFI > 1) ? $clog2(REFI) : 1;

    logic [TW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == TW'(REFI - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            // A wrap on the ack cycle re-arms the request
            if (wrap)
                ref_pending <= 1'b1;
            else if (ref_ack)
                ref_pending <= 1'b0;
            if (wrap && ref_pending && !ref_ack)
                ref_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_access_arbiter.sv
// Arbitrates refresh, display and user read/write traffic onto
// a single SDRAM controller command port.
module sdram_access_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFI       = 780,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_cmd_vld,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_busy,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ref_overrun
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t        state;
    owner_t        owner;
    owner_t        win;
    logic          fav_wr;
    logic [SW-1:0] starve;
    logic          ref_pending;
    logic          ref_ack;
    logic          user_pend;
    logic          pick_wr;
    logic          starved;

    assign ref_ack   = (state == ISSUE) && (owner == OWN_REF);
    assign user_pend = wr_req || rd_req;
    assign pick_wr   = wr_req && (!rd_req || fav_wr);
    assign starved   = user_pend && (starve == SW'(STARVE_MAX));

    sdram_refresh_timer #(
        .REFI(REFI)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .ref_ack    (ref_ack),
        .ref_pending(ref_pending),
        .ref_overrun(ref_overrun)
    );

    always_comb begin
        win = OWN_NONE;
        if (ref_pending)
            win = OWN_REF;
        else if (starved)
            win = pick_wr ? OWN_USER_WR : OWN_USER_RD;
        else if (disp_req)
            win = OWN_DISP;
        else if (user_pend)
            win = pick_wr ? OWN_USER_WR : OWN_USER_RD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            mem_cmd_vld <= 1'b0;
            mem_cmd     <= CMD_NOP;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            disp_gnt    <= 1'b0;
            wr_gnt      <= 1'b0;
            rd_gnt      <= 1'b0;
            fav_wr      <= 1'b1;
            starve      <= '0;
        end else begin
            mem_cmd_vld <= 1'b0;
            disp_gnt    <= 1'b0;
            wr_gnt      <= 1'b0;
            rd_gnt      <= 1'b0;
            if (!user_pend)
                starve <= '0;
            unique case (state)
                IDLE: begin
                    if (!mem_busy && win != OWN_NONE) begin
                        state       <= ISSUE;
                        owner       <= win;
                        mem_cmd_vld <= 1'b1;
                        mem_wdata   <= '0;
                        unique case (win)
                            OWN_REF: begin
                                mem_cmd  <= CMD_REF;
                                mem_addr <= '0;
                            end
                            OWN_DISP: begin
                                mem_cmd  <= CMD_RD;
                                mem_addr <= disp_addr;
                                disp_gnt <= 1'b1;
                                if (user_pend)
                                    starve <= starve + 1'b1;
                            end
                            OWN_USER_WR: begin
                                mem_cmd   <= CMD_WR;
                                mem_addr  <= wr_addr;
                                mem_wdata <= wr_data;
                                wr_gnt    <= 1'b1;
                                fav_wr    <= 1'b0;
                                starve    <= '0;
                            end
                            OWN_USER_RD: begin
                                mem_cmd  <= CMD_RD;
                                mem_addr <= rd_addr;
                                rd_gnt   <= 1'b1;
                                fav_wr   <= 1'b1;
                                starve   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: state <= GUARD;
                GUARD: state <= WAIT;
                WAIT: begin
                    if (!mem_busy) begin
                        state <= IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign disp_data  = mem_rdata;
    assign rd_data    = mem_rdata;
    assign disp_valid = mem_rvalid && (owner == OWN_DISP);
    assign rd_valid   = mem_rvalid && (owner == OWN_USER_RD);

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Directed bench for sdram_access_arbiter: arbitration table plus
// starvation, refresh, overrun, read-return and reset sequences.
module tb_sdram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        disp_req = 1'b0;
    logic [21:0] disp_addr = '0;
    logic        disp_gnt, disp_valid;
    logic [15:0] disp_data;
    logic        wr_req = 1'b0;
    logic [21:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_gnt;
    logic        rd_req = 1'b0;
    logic [21:0] rd_addr = '0;
    logic        rd_gnt, rd_valid;
    logic [15:0] rd_data;
    logic        mem_cmd_vld;
    logic [1:0]  mem_cmd;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_busy = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        ref_overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_access_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_gnt   (disp_gnt),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_gnt     (wr_gnt),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .mem_cmd_vld(mem_cmd_vld),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_busy   (mem_busy),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ref_overrun(ref_overrun)
    );

    typedef struct {
        logic        disp, wr, rd;
        logic [21:0] da, wa, ra;
        logic [15:0] wd;
        logic        vld;
        logic [1:0]  cmd;
        logic [21:0] addr;
        logic [15:0] wdata;
        logic [2:0]  gnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [2:0] gnts();
        return {disp_gnt, wr_gnt, rd_gnt};
    endfunction

    task automatic do_reset(input logic busy);
        rst        = 1'b0;
        disp_req   = 1'b0;
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        mem_rvalid = 1'b0;
        mem_busy   = busy;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_vld"}, 32'(mem_cmd_vld), 0);
        chk({tag, "_cmd"}, 32'(mem_cmd), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_gnt"}, 32'(gnts()), 0);
        chk({tag, "_valids"}, 32'({disp_valid, rd_valid}), 0);
        chk({tag, "_ovr"}, 32'(ref_overrun), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] seq [6];
        logic [2:0] exp_seq [6];
        int n, first, nref, nvld;

        vecs[0] = '{0,1,0, 22'h0, 22'h012345, 22'h0, 16'hBEEF,
                    1, 2'b10, 22'h012345, 16'hBEEF, 3'b010};
        vecs[1] = '{0,0,1, 22'h0, 22'h0, 22'h2AAAAA, 16'h0,
                    1, 2'b01, 22'h2AAAAA, 16'h0, 3'b001};
        vecs[2] = '{0,1,1, 22'h0, 22'h3FFFFF, 22'h155555, 16'h0001,
                    1, 2'b10, 22'h3FFFFF, 16'h0001, 3'b010};
        vecs[3] = '{0,1,1, 22'h0, 22'h000001, 22'h2C0DE0, 16'hFFFF,
                    1, 2'b01, 22'h2C0DE0, 16'h0, 3'b001};
        vecs[4] = '{1,1,0, 22'h1ABCDE, 22'h000002, 22'h0, 16'h1111,
                    1, 2'b01, 22'h1ABCDE, 16'h0, 3'b100};
        vecs[5] = '{1,0,1, 22'h000000, 22'h0, 22'h000003, 16'h0,
                    1, 2'b01, 22'h000000, 16'h0, 3'b100};
        vecs[6] = '{0,0,1, 22'h0, 22'h0, 22'h0F0F0F, 16'h0,
                    1, 2'b01, 22'h0F0F0F, 16'h0, 3'b001};
        vecs[7] = '{0,0,0, 22'h0, 22'h0, 22'h0, 16'h0,
                    0, 2'b00, 22'h0, 16'h0, 3'b000};

        // Reset values, both during and after reset
        #1;
        chk_reset_outs("rst_in");
        do_reset(1'b0);
        #1;
        chk_reset_outs("rst_out");

        // Arbitration table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            disp_req  = vecs[i].disp;
            wr_req    = vecs[i].wr;
            rd_req    = vecs[i].rd;
            disp_addr = vecs[i].da;
            wr_addr   = vecs[i].wa;
            rd_addr   = vecs[i].ra;
            wr_data   = vecs[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vld", i),
                32'(mem_cmd_vld), 32'(vecs[i].vld));
            chk($sformatf("v%0d_gnt", i),
                32'(gnts()), 32'(vecs[i].gnt));
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_cmd", i),
                    32'(mem_cmd), 32'(vecs[i].cmd));
                chk($sformatf("v%0d_addr", i),
                    32'(mem_addr), 32'(vecs[i].addr));
                chk($sformatf("v%0d_wdata", i),
                    32'(mem_wdata), 32'(vecs[i].wdata));
            end
            disp_req = 1'b0;
            wr_req   = 1'b0;
            rd_req   = 1'b0;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse", i),
                32'({mem_cmd_vld, gnts()}), 0);
            repeat (2) @(posedge clk);
        end

        // Starvation: display and write held together
        do_reset(1'b0);
        exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100,
                    3'b010, 3'b100};
        disp_req  = 1'b1;
        disp_addr = 22'h000100;
        wr_req    = 1'b1;
        wr_addr   = 22'h000200;
        wr_data   = 16'h5A5A;
        n = 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(posedge clk);
            #1;
            if (gnts() != 3'b000) begin
                seq[n] = gnts();
                n++;
            end
        end
        chk("starve_count", 32'(n), 6);
        for (int k = 0; k < 6; k++)
            if (k < n)
                chk($sformatf("starve_g%0d", k),
                    32'(seq[k]), 32'(exp_seq[k]));
        disp_req = 1'b0;
        wr_req   = 1'b0;

        // Refresh while display streams
        do_reset(1'b0);
        disp_req = 1'b1;
        first = 0;
        nref  = 0;
        for (int c = 1; c <= 900; c++) begin
            @(posedge clk);
            #1;
            if (mem_cmd_vld && mem_cmd == 2'b11) begin
                if (first == 0)
                    first = c;
                nref++;
            end
        end
        chk("ref_window", 32'(first >= 781 && first <= 785), 1);
        chk("ref_count", 32'(nref), 1);
        chk("ref_no_ovr", 32'(ref_overrun), 0);
        disp_req = 1'b0;

        // Overrun: controller busy for 1600 cycles
        do_reset(1'b1);
        nvld = 0;
        for (int c = 1; c <= 1600; c++) begin
            @(posedge clk);
            #1;
            if (mem_cmd_vld)
                nvld++;
            if (c == 1559)
                chk("ovr_1559", 32'(ref_overrun), 0);
            if (c == 1560)
                chk("ovr_1560", 32'(ref_overrun), 1);
        end
        chk("ovr_1600", 32'(ref_overrun), 1);
        chk("ovr_no_cmd", 32'(nvld), 0);
        mem_busy = 1'b0;
        nref = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (mem_cmd_vld && mem_cmd == 2'b11)
                nref++;
        end
        chk("ovr_ref_after", 32'(nref), 1);
        chk("ovr_sticky", 32'(ref_overrun), 1);

        // Wrap coinciding with refresh ISSUE
        do_reset(1'b1);
        repeat (1558) @(posedge clk);
        #1;
        mem_busy = 1'b0;
        @(posedge clk);
        #1;
        chk("coin_issue",
            32'({mem_cmd_vld, mem_cmd}), 32'(3'b111));
        @(posedge clk);
        #1;
        chk("coin_no_ovr", 32'(ref_overrun), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("coin_reissue",
            32'({mem_cmd_vld, mem_cmd}), 32'(3'b111));
        chk("coin_no_ovr2", 32'(ref_overrun), 0);

        // Read return routing
        do_reset(1'b0);
        rd_req  = 1'b1;
        rd_addr = 22'h00ABCD;
        @(posedge clk);
        #1;
        chk("rr_gnt", 32'(gnts()), 32'(3'b001));
        rd_req   = 1'b0;
        mem_busy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h1234;
        #1;
        chk("rr_valid", 32'({rd_valid, disp_valid}), 32'(2'b10));
        chk("rr_data", 32'(rd_data), 32'h1234);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_busy   = 1'b0;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'h5555;
        #1;
        chk("rr_idle_drop", 32'({rd_valid, disp_valid}), 0);
        mem_rvalid = 1'b0;
        @(negedge clk);
        disp_req  = 1'b1;
        disp_addr = 22'h000777;
        @(posedge clk);
        #1;
        chk("dr_gnt", 32'(gnts()), 32'(3'b100));
        disp_req = 1'b0;
        mem_busy = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hCAFE;
        #1;
        chk("dr_valid", 32'({rd_valid, disp_valid}), 32'(2'b01));
        chk("dr_data", 32'(disp_data), 32'hCAFE);
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_busy   = 1'b0;
        repeat (3) @(negedge clk);
        wr_req  = 1'b1;
        wr_addr = 22'h000042;
        wr_data = 16'h0042;
        @(posedge clk);
        #1;
        chk("wr_gnt", 32'(gnts()), 32'(3'b010));
        wr_req   = 1'b0;
        mem_busy = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1;
        #1;
        chk("wr_drop", 32'({rd_valid, disp_valid}), 0);
        mem_rvalid = 1'b0;
        mem_busy   = 1'b0;

        // Reset asserted in WAIT
        do_reset(1'b0);
        wr_req  = 1'b1;
        wr_addr = 22'h012345;
        wr_data = 16'hBEEF;
        @(posedge clk);
        #1;
        chk("rw_gnt", 32'(gnts()), 32'(3'b010));
        wr_req   = 1'b0;
        mem_busy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk_reset_outs("rw");
        @(negedge clk);
        rst        = 1'b1;
        mem_rvalid = 1'b0;
        mem_busy   = 1'b0;
        nvld = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (mem_cmd_vld || gnts() != 3'b000)
                nvld++;
        end
        chk("rw_no_grant", 32'(nvld), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
